// File: rtl/bp_resolve_queue.sv
// In-order branch resolution queue: produces PHT training updates, flush/redirect and GHR recovery.
// Optional BPQ_STATS_EN adds resolved-branch and mispredict counters.
module bp_resolve_queue #(
    parameter int DEPTH     = 4,
    parameter int PHT_DEPTH = 7,
    parameter int GHR_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_valid,
    output logic                    push_ready,
    input  logic [PHT_DEPTH-1:0]    push_pht_index,
    input  logic                    push_pred_taken,
    input  logic [31:0]             push_target,
    input  logic [31:0]             push_fallthrough,
    input  logic [GHR_WIDTH-1:0]    push_ghr_alt,
    input  logic                    resolve_valid,
    input  logic                    resolve_taken,
    input  logic [31:0]             resolve_target,
    output logic                    upd_valid,
    output logic [PHT_DEPTH-1:0]    upd_pht_index,
    output logic                    upd_taken,
    output logic                    flush,
    output logic [31:0]             redirect_pc,
    output logic                    recover_ghr_valid,
    output logic [GHR_WIDTH-1:0]    recover_ghr,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty
`ifdef BPQ_STATS_EN
    ,
    output logic [31:0]             stat_branches,
    output logic [31:0]             stat_mispredicts
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Returns {direction_mispredict, target_mispredict}; target only matters when both say taken.
    function automatic logic [1:0] f_mispredict(
        input logic        pred_taken,
        input logic [31:0] pred_target,
        input logic        res_taken,
        input logic [31:0] res_target
    );
        logic w_dir;
        logic w_tgt;
        w_dir = (res_taken != pred_taken);
        w_tgt = res_taken & pred_taken & (res_target != pred_target);
        return {w_dir, w_tgt};
    endfunction

    logic [PHT_DEPTH-1:0] r_pht_index   [DEPTH];
    logic                 r_pred_taken  [DEPTH];
    logic [31:0]          r_target      [DEPTH];
    logic [31:0]          r_fallthrough [DEPTH];
    logic [GHR_WIDTH-1:0] r_ghr_alt     [DEPTH];

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_push_acc;
    logic             w_res_acc;
    logic             w_dir_mis;
    logic             w_tgt_mis;
    logic             w_mis;
    logic [CNT_W-1:0] w_count_nxt;

    assign count      = r_count;
    assign empty      = (r_count == CNT_W'(0));
    assign push_ready = (r_count != CNT_W'(DEPTH));

    assign w_push_acc = push_valid & push_ready;
    assign w_res_acc  = resolve_valid & ~empty;
    assign {w_dir_mis, w_tgt_mis} = f_mispredict(r_pred_taken[r_head], r_target[r_head],
                                                 resolve_taken, resolve_target);
    assign w_mis      = w_res_acc & (w_dir_mis | w_tgt_mis);

    // Next occupancy: a mispredict empties the queue and also swallows any same-cycle push.
    always_comb begin
        w_count_nxt = r_count;
        if (w_mis) begin
            w_count_nxt = CNT_W'(0);
        end else begin
            case ({w_push_acc, w_res_acc})
                2'b10:   w_count_nxt = r_count + CNT_W'(1);
                2'b01:   w_count_nxt = r_count - CNT_W'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Head/tail/count bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= PTR_W'(0);
            r_tail  <= PTR_W'(0);
            r_count <= CNT_W'(0);
        end else begin
            r_count <= w_count_nxt;
            if (w_mis) begin
                r_head <= PTR_W'(0);
                r_tail <= PTR_W'(0);
            end else begin
                if (w_push_acc) r_tail <= r_tail + PTR_W'(1);
                if (w_res_acc)  r_head <= r_head + PTR_W'(1);
            end
        end
    end

    // Entry payload; contents are only ever read behind a valid count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push_acc && !w_mis) begin
            r_pht_index[r_tail]   <= push_pht_index;
            r_pred_taken[r_tail]  <= push_pred_taken;
            r_target[r_tail]      <= push_target;
            r_fallthrough[r_tail] <= push_fallthrough;
            r_ghr_alt[r_tail]     <= push_ghr_alt;
        end
    end

    // Registered training and recovery outputs; data fields hold between events.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_valid         <= 1'b0;
            upd_pht_index     <= PHT_DEPTH'(0);
            upd_taken         <= 1'b0;
            flush             <= 1'b0;
            redirect_pc       <= 32'h0000_0000;
            recover_ghr_valid <= 1'b0;
            recover_ghr       <= GHR_WIDTH'(0);
        end else begin
            upd_valid         <= w_res_acc;
            flush             <= w_mis;
            recover_ghr_valid <= w_mis & w_dir_mis;
            if (w_res_acc) begin
                upd_pht_index <= r_pht_index[r_head];
                upd_taken     <= resolve_taken;
            end
            if (w_mis) begin
                redirect_pc <= resolve_taken ? resolve_target : r_fallthrough[r_head];
            end
            if (w_mis && w_dir_mis) begin
                recover_ghr <= r_ghr_alt[r_head];
            end
        end
    end

`ifdef BPQ_STATS_EN
    // Free-running statistics, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_branches    <= 32'h0000_0000;
            stat_mispredicts <= 32'h0000_0000;
        end else begin
            if (w_res_acc) stat_branches    <= stat_branches + 32'h0000_0001;
            if (w_mis)     stat_mispredicts <= stat_mispredicts + 32'h0000_0001;
        end
    end
`endif

endmodule

// File: doc/bp_resolve_queue.md
# bp_resolve_queue

Branch resolution tracker that consumes the global-history predictor's per-branch predictions and produces its training and recovery traffic. Each predicted branch is pushed, in program order, into a small FIFO with its PHT index, predicted direction and target, and checkpointed alternate GHR. When the execute stage resolves the oldest branch, the block emits a PHT update and detects mispredictions. On a misprediction it also emits a pipeline flush, a redirect PC and the recovery GHR, and discards all younger entries.

## Interface
Parameters:
- DEPTH, 4, entry count; power of two, at least 2
- PHT_DEPTH, 7, PHT index width
- GHR_WIDTH, 4, global history width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- push_valid  in  1  new predicted branch
- push_ready  out  1  queue not full; equals count != DEPTH
- push_pht_index  in  PHT_DEPTH  PHT index used for the prediction
- push_pred_taken  in  1  predicted direction
- push_target  in  32  predicted taken target
- push_fallthrough  in  32  not-taken PC (branch PC + 8)
- push_ghr_alt  in  GHR_WIDTH  GHR with the opposite direction shifted in
- resolve_valid  in  1  oldest branch resolved this cycle
- resolve_taken  in  1  actual direction
- resolve_target  in  32  actual taken target
- upd_valid  out  1  PHT update pulse
- upd_pht_index  out  PHT_DEPTH  index to update
- upd_taken  out  1  training outcome
- flush  out  1  mispredict pulse
- redirect_pc  out  32  correct fetch PC, valid with flush
- recover_ghr_valid  out  1  load recover_ghr into GHR
- recover_ghr  out  GHR_WIDTH  recovery history
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count == 0

## Operation
- The storage is a circular buffer with head/tail pointers of width $clog2(DEPTH). Pointers wrap modulo DEPTH.
- Push: accepted when push_valid && push_ready. The entry is written at the tail and the tail increments. A push while full is dropped silently and no state changes.
- Resolve: applies to the head entry. If resolve_valid arrives while the queue is empty, it is ignored: no update and no flush.
- Misprediction is detected in either of two cases:
  - direction mispredict: resolve_taken != pred_taken
  - target mispredict: resolve_taken && pred_taken && resolve_target != stored target
- Correctly predicted resolve:
  - The head increments.
  - upd_valid pulses with the head's pht_index and resolve_taken.
- Mispredicted resolve:
  - upd_valid pulses as above.
  - flush pulses.
  - redirect_pc = resolve_taken ? resolve_target : fallthrough.
  - On a direction mispredict, recover_ghr_valid=1 and recover_ghr=ghr_alt. On a target mispredict, recover_ghr_valid=0.
  - Head, tail and count all clear to 0, which discards all younger wrong-path entries.
- Simultaneous push and resolve:
  - If the resolve is correct, both take effect and count is unchanged.
  - If the resolve mispredicts, the push is discarded because it is wrong-path.
- push_ready does not anticipate a same-cycle pop. A full queue refuses a push even when a resolve is present.

## Timing
- Reset (asserted asynchronously) sets:
  - head, tail and count to 0, so empty=1 and push_ready=1
  - upd_valid, flush and recover_ghr_valid to 0
  - upd_pht_index, upd_taken, redirect_pc and recover_ghr to 0
- Reset asserted mid-operation discards all entries immediately. Reset deassertion is synchronised by the integrating design.
- upd_*, flush, redirect_pc and recover_* are registered. They are valid in the cycle after the resolve edge and pulse for exactly one cycle. Data outputs hold their value until the next event.
- count, empty and push_ready reflect state after the last edge; push_ready is combinational from count.
- A push is resolvable at the earliest in the cycle after it is accepted.
- Throughput is one push and one resolve per cycle.

## Configuration
- BPQ_STATS_EN defined:
  - Adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - stat_branches increments on every accepted resolve; stat_mispredicts increments on every mispredict.
  - Both counters wrap at 2^32 and reset to 0.
- BPQ_STATS_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset: drive rst=0 mid-run with count=3 -> count=0, empty=1, push_ready=1, flush=0, upd_valid=0.
- Fill: DEPTH=4, push 5 entries on consecutive cycles -> push_ready=0 after the 4th, the 5th is dropped, count=4; draining 4 correct resolves returns empty=1 with head wrapped to 0.
- Correct taken: push pred_taken=1, target 0x100, index 0x2A; resolve taken=1, target 0x100 -> next cycle upd_valid=1, upd_pht_index=0x2A, upd_taken=1, flush=0.
- Direction mispredict: push 3 entries, head pred_taken=0, fallthrough 0x208, ghr_alt=4'b0101; resolve taken=1, target 0x400 -> flush=1, redirect_pc=0x400, recover_ghr_valid=1, recover_ghr=0101, count=0; a same-cycle push is not enqueued.
- Target mispredict: push pred_taken=1, target 0x100; resolve taken=1, target 0x180 -> flush=1, redirect_pc=0x180, recover_ghr_valid=0.
- Empty resolve and stats: resolve_valid with empty=1 -> no upd_valid and no flush. With BPQ_STATS_EN, after the above sequence, stat_branches and stat_mispredicts match the counts of accepted resolves and mispredicts.
